// File: rtl/hc165_reader.sv
// Reads a 74HC165 chain into an N-bit word on request: one SH_LD load pulse, then N QH samples
// separated by N-1 SRCLK pulses. Define HC165_SYNC_EN to pass QH through a 2-flop synchronizer.
module hc165_reader #(
  parameter int N            = 8,
  parameter int SETUP_CYCLES = 200,
  parameter int PULSE_CYCLES = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         QH,
  output logic         SH_LD,
  output logic         SRCLK,
  output logic         RDY,
  output logic [N-1:0] data_out,
  output logic         valid
);
  localparam int MAX_CYC = (PULSE_CYCLES > SETUP_CYCLES) ? PULSE_CYCLES : SETUP_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] S_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [5:0]    N_BITS = 6'(N);

  typedef enum logic [2:0] {
    IDLE, LOAD_LO, LOAD_SETUP, SAMPLE, CLK_HI, CLK_LO, DONE
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [5:0]    cnt, cnt_nx;
  logic [N-1:0]  sr, sr_nx;
  logic [N-1:0]  data_nx;
  logic          sh_ld_nx, srclk_nx, rdy_nx, valid_nx;
  logic          qh_smp;

  if (N < 1 || N > 32) begin : g_n_chk
    $error("hc165_reader: N must be in 1..32");
  end

`ifdef HC165_SYNC_EN
  logic qh_s1, qh_s2;

  if (SETUP_CYCLES < 3) begin : g_setup_chk
    $error("hc165_reader: SETUP_CYCLES must be >= 3 with the QH synchronizer");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qh_s1 <= 1'b0;
      qh_s2 <= 1'b0;
    end else begin
      qh_s1 <= QH;
      qh_s2 <= qh_s1;
    end
  end

  assign qh_smp = qh_s2;
`else
  assign qh_smp = QH;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      cnt      <= '0;
      sr       <= '0;
      data_out <= '0;
      SH_LD    <= 1'b1;
      SRCLK    <= 1'b0;
      RDY      <= 1'b1;
      valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      cnt      <= cnt_nx;
      sr       <= sr_nx;
      data_out <= data_nx;
      SH_LD    <= sh_ld_nx;
      SRCLK    <= srclk_nx;
      RDY      <= rdy_nx;
      valid    <= valid_nx;
    end
  end

  // Outputs are computed one cycle ahead so every pin leaves a flop.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    cnt_nx   = cnt;
    sr_nx    = sr;
    data_nx  = data_out;
    sh_ld_nx = SH_LD;
    srclk_nx = SRCLK;
    rdy_nx   = RDY;
    valid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_nx = 1'b1;
        if (start && RDY) begin
          state_nx = LOAD_LO;
          rdy_nx   = 1'b0;
          cnt_nx   = '0;
          timer_nx = '0;
          sh_ld_nx = 1'b0;
        end
      end
      LOAD_LO: begin
        if (timer == P_LAST) begin
          state_nx = LOAD_SETUP;
          timer_nx = '0;
          sh_ld_nx = 1'b1;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      LOAD_SETUP: begin
        if (timer == S_LAST) begin
          state_nx = SAMPLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      SAMPLE: begin
        sr_nx    = sr << 1;
        sr_nx[0] = qh_smp;
        cnt_nx   = cnt + 6'd1;
        timer_nx = '0;
        if (cnt + 6'd1 == N_BITS) begin
          state_nx = DONE;
        end else begin
          state_nx = CLK_HI;
          srclk_nx = 1'b1;
        end
      end
      CLK_HI: begin
        if (timer == P_LAST) begin
          state_nx = CLK_LO;
          timer_nx = '0;
          srclk_nx = 1'b0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      CLK_LO: begin
        if (timer == S_LAST) begin
          state_nx = SAMPLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      DONE: begin
        data_nx  = sr;
        valid_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: behavioural HC165 chains drive an N=8 and an N=1 instance (P=S=2);
// captured words and handshake timing are compared against values derived from the chain contents.
`timescale 1ns/1ps
module tb_hc165_reader;
  localparam int N  = 8;
  localparam int P  = 2;
  localparam int S  = 2;
  localparam int T  = N * (P + S + 1) + 1;
  localparam int T1 = 1 * (P + S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       qh, sh_ld, srclk, rdy, valid;
  logic [7:0] data_out;
  logic       start1 = 1'b0;
  logic       qh1, sh_ld1, srclk1, rdy1, valid1;
  logic [0:0] data_out1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  hc165_reader #(.N(N), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .QH(qh),
    .SH_LD(sh_ld), .SRCLK(srclk), .RDY(rdy), .data_out(data_out), .valid(valid)
  );

  hc165_reader #(.N(1), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .QH(qh1),
    .SH_LD(sh_ld1), .SRCLK(srclk1), .RDY(rdy1), .data_out(data_out1), .valid(valid1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural chain: a load presents bit N-1 on QH, each SRCLK rise advances one bit.
  logic [7:0] par = 8'h00;
  int         shifts = 0;
  always @(negedge sh_ld) shifts <= 0;
  always @(posedge srclk) if (sh_ld) shifts <= shifts + 1;
  assign qh = (shifts < N) ? par[N-1-shifts] : 1'b0;

  logic par1 = 1'b0;
  int   shifts1 = 0;
  always @(negedge sh_ld1) shifts1 <= 0;
  always @(posedge srclk1) if (sh_ld1) shifts1 <= shifts1 + 1;
  assign qh1 = (shifts1 == 0) ? par1 : 1'b0;

  // Pulse and strobe monitors, sampled on the falling clock edge.
  int         shld_falls = 0, srclk_rises = 0, vcount = 0, vcyc = 0, lo_w = 0, hi_w = 0;
  logic [7:0] vdata = 8'h00;
  logic       p_shld = 1'b1, p_srclk = 1'b0, p_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_shld  <= 1'b1;
      p_srclk <= 1'b0;
      p_valid <= 1'b0;
      lo_w    <= 0;
      hi_w    <= 0;
    end else begin
      if (p_shld && !sh_ld) shld_falls <= shld_falls + 1;
      if (!sh_ld) lo_w <= lo_w + 1;
      else if (!p_shld) begin
        check("shld_low_width", 32'(lo_w), 32'(P));
        lo_w <= 0;
      end
      if (!p_srclk && srclk) srclk_rises <= srclk_rises + 1;
      if (srclk) hi_w <= hi_w + 1;
      else if (p_srclk) begin
        check("srclk_high_width", 32'(hi_w), 32'(P));
        hi_w <= 0;
      end
      if (valid) begin
        vcount <= vcount + 1;
        vcyc   <= cyc;
        vdata  <= data_out;
        check("valid_one_cycle", 32'(p_valid), 32'd0);
      end
      p_shld  <= sh_ld;
      p_srclk <= srclk;
      p_valid <= valid;
    end
  end

  int srclk1_rises = 0, vcount1 = 0;
  logic p_srclk1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) p_srclk1 <= 1'b0;
    else begin
      if (!p_srclk1 && srclk1) srclk1_rises <= srclk1_rises + 1;
      if (valid1) vcount1 <= vcount1 + 1;
      p_srclk1 <= srclk1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] w);
    int e0, f0, r0, v0, rdy_hi;
    par    = w;
    f0     = shld_falls;
    r0     = srclk_rises;
    v0     = vcount;
    rdy_hi = 0;
    start  = 1'b1;
    e0     = cyc + 1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= T; i++) begin
      if (rdy) rdy_hi++;
      if (i < T) tick();
    end
    check("rdy_low_while_busy", 32'(rdy_hi), 32'd0);
    check("valid_at_edge", 32'(valid), 32'd1);
    check("data_out", 32'(data_out), 32'(w));
    tick();
    check("rdy_back", 32'(rdy), 32'd1);
    check("valid_dropped", 32'(valid), 32'd0);
    check("valid_count", 32'(vcount - v0), 32'd1);
    check("valid_cycle", 32'(vcyc - e0), 32'(T));
    check("shld_pulses", 32'(shld_falls - f0), 32'd1);
    check("srclk_pulses", 32'(srclk_rises - r0), 32'(N - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, v0, f0, v1c, v2c, gap;
    logic [7:0] v1d, v2d, w;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      check("idle8", 32'({sh_ld, srclk, rdy, valid, data_out}), 32'h0A00);
      check("idle1", 32'({sh_ld1, srclk1, rdy1, valid1, data_out1}), 32'h14);
    end

    // Single capture, then randomized words with random idle gaps
    capture(8'hA5);
    for (int k = 0; k < 6; k++) begin
      w   = 8'($urandom);
      gap = $urandom_range(0, 4);
      repeat (gap) tick();
      capture(w);
    end

    // Back-to-back with start held high
    par   = 8'h3C;
    v0    = vcount;
    v1c   = 0;
    v1d   = 8'h00;
    start = 1'b1;
    e0    = cyc + 1;
    for (int i = 0; i < 2 * T + 10; i++) begin
      tick();
      if (vcount - v0 == 1 && par != 8'hFF) begin
        v1c = vcyc;
        v1d = vdata;
        par = 8'hFF;
      end
      if (vcount - v0 == 2) break;
    end
    start = 1'b0;
    v2c = vcyc;
    v2d = vdata;
    check("b2b_count", 32'(vcount - v0), 32'd2);
    check("b2b_first_cycle", 32'(v1c - e0), 32'(T));
    check("b2b_first_data", 32'(v1d), 32'h3C);
    check("b2b_spacing", 32'(v2c - v1c), 32'(T + 2));
    check("b2b_second_data", 32'(v2d), 32'hFF);
    repeat (4) tick();

    // Start pulses while busy are ignored
    par   = 8'h01;
    v0    = vcount;
    f0    = shld_falls;
    start = 1'b1;
    e0    = cyc + 1;
    tick();
    start = 1'b0;
    while (cyc < e0 + T + 4) begin
      start = (cyc == e0 + 9 || cyc == e0 + 29);
      tick();
    end
    start = 1'b0;
    check("busy_valid_count", 32'(vcount - v0), 32'd1);
    check("busy_data", 32'(vdata), 32'h01);
    check("busy_shld_pulses", 32'(shld_falls - f0), 32'd1);
    check("busy_rdy_idle", 32'(rdy), 32'd1);

    // Reset in the middle of a capture
    par   = 8'h5A;
    v0    = vcount;
    start = 1'b1;
    e0    = cyc + 1;
    tick();
    start = 1'b0;
    while (cyc < e0 + 20) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({sh_ld, srclk, rdy, valid}), 32'hA);
    check("midrst_data", 32'(data_out), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    check("midrst_no_valid", 32'(vcount - v0), 32'd0);
    check("midrst_data_held", 32'(data_out), 32'h00);
    capture(8'h5A);

    // Single-bit build
    for (int k = 0; k < 2; k++) begin
      par1   = (k == 0);
      v0     = vcount1;
      f0     = srclk1_rises;
      start1 = 1'b1;
      e0     = cyc + 1;
      tick();
      start1 = 1'b0;
      while (cyc < e0 + T1) tick();
      check("n1_valid", 32'(valid1), 32'd1);
      check("n1_data", 32'(data_out1), 32'(par1));
      tick();
      check("n1_valid_drop", 32'(valid1), 32'd0);
      check("n1_rdy", 32'(rdy1), 32'd1);
      check("n1_valid_count", 32'(vcount1 - v0), 32'd1);
      check("n1_srclk_pulses", 32'(srclk1_rises - f0), 32'd0);
      repeat (2) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hc165_reader.md
Name: hc165_reader

Overview:
- Drives a chain of 74HC165 parallel-in/serial-out shift registers to capture N parallel inputs (switches or buttons) into a register.
- It is the input-side counterpart of the HC595 output driver and uses the same start/ready handshake and pulse-timing style.
- It sits between the board's HC165 chain and user logic, which requests a capture and receives a parallel word with a one-cycle valid strobe.

Parameters:
- N, 8: number of bits captured; legal range 1..32.
- SETUP_CYCLES, 200: clk cycles SH_LD or SRCLK is held low/idle before the next action (2 us at 100 MHz); minimum 1, or 3 with HC165_SYNC_EN.
- PULSE_CYCLES, 200: clk cycles of each SH_LD-low or SRCLK-high pulse; minimum 1.

Ports:
- clk  input  1  system clock, 100 MHz; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  capture request; accepted only when RDY=1.
- QH  input  1  serial data from the last HC165 in the chain.
- SH_LD  output  1  HC165 shift/load; 0 = parallel load.
- SRCLK  output  1  HC165 shift clock (CLK pin); CLK_INH is tied low on the board.
- RDY  output  1  1 = idle and able to accept start.
- data_out  output  N  last captured word; bit N-1 is the first bit sampled (the HC165 H input of the last device).
- valid  output  1  one-cycle strobe when data_out updates.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, SH_LD=1, SRCLK=0, RDY=1, valid=0, data_out=0.
  - Shift register, bit counter and timer are cleared.
  - Reset mid-capture aborts immediately to these values. No partial data_out, no valid.
- SH_LD, SRCLK, RDY and valid are registered outputs (no combinational glitches).
- State machine (timer counts clk cycles in each timed state):
  - IDLE: RDY=1. If start=1 then go to LOAD_LO, RDY<=0, and clear the bit counter. start while RDY=0 is ignored, not queued.
  - LOAD_LO: SH_LD=0 for PULSE_CYCLES, then go to LOAD_SETUP.
  - LOAD_SETUP: SH_LD=1 for SETUP_CYCLES, then go to SAMPLE.
  - SAMPLE (1 cycle):
    - Shift the QH sample into the LSB of the internal shift register (left shift); count++.
    - If count reaches N, go to DONE; otherwise go to CLK_HI.
  - CLK_HI: SRCLK=1 for PULSE_CYCLES, then go to CLK_LO.
  - CLK_LO: SRCLK=0 for SETUP_CYCLES, then go to SAMPLE.
  - DONE (1 cycle): data_out<=shift register, valid=1. Next state is IDLE with RDY<=1.
- Counts per capture:
  - exactly N samples and N-1 SRCLK rising edges;
  - one SH_LD low pulse.
- N=1: no SRCLK pulse is issued.
- Timing, with start accepted at edge 0 and P=PULSE_CYCLES, S=SETUP_CYCLES:
  - k-th sample (k=1..N) occurs at edge k*(P+S+1).
  - valid=1 and the new data_out are visible after edge N*(P+S+1)+1.
  - RDY returns to 1 one edge later.
  - start held high continuously gives back-to-back captures with one IDLE cycle between them.
- data_out holds its value between captures. valid is never high for more than one cycle.
- Timer width is sized to max(PULSE_CYCLES, SETUP_CYCLES). Bit counter is 6 bits.
- QH is sampled only in SAMPLE. It is never sampled within S cycles after an SRCLK or SH_LD edge.

Optional Feature:
- HC165_SYNC_EN defined: QH passes through a 2-flop synchronizer before sampling.
  - Sample instants and latency are unchanged.
  - SETUP_CYCLES must be >=3; an elaboration-time check enforces this.
- HC165_SYNC_EN undefined: QH is sampled directly, assuming it is board-synchronous via setup time. SETUP_CYCLES>=1.

Test Plan:
Bench uses a behavioural HC165 model, N=8, P=S=2.
1. Reset then idle:
   - Stimulus: rst_n low 3 cycles, release, start=0 for 20 cycles.
   - Required: SH_LD=1, SRCLK=0, RDY=1, valid=0, data_out=0 throughout.
2. Single capture:
   - Stimulus: parallel inputs 8'hA5, start pulse for 1 cycle.
   - Required: exactly 1 SH_LD low pulse of 2 cycles; exactly 7 SRCLK pulses, each 2 cycles high.
   - Required: valid high for 1 cycle after edge 41 with data_out=8'hA5; RDY low edges 1..41, high at 42.
3. Back-to-back:
   - Stimulus: start held high; inputs changed 8'h3C then 8'hFF between captures.
   - Required: two valid strobes 43 cycles apart, with data_out=8'h3C then 8'hFF.
4. Start while busy:
   - Stimulus: start pulses at edges 10 and 30 of a capture of 8'h01.
   - Required: a single valid with data_out=8'h01; no extra SH_LD pulse.
5. Reset mid-capture:
   - Stimulus: rst_n asserted at edge 20 of a capture of 8'h5A.
   - Required: outputs at reset values immediately; data_out=0; no valid.
   - Required: a following capture of 8'h5A returns 8'h5A.
6. N=1 build:
   - Stimulus: N=1, input 1, start.
   - Required: zero SRCLK pulses; valid after edge 6 with data_out=1'b1.
